k6502_seq: RTL and testbench
============================

K6502_SEQ -- requirements
Module: k6502_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single core clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port rdy, input, 1 bit: bus ready; low stalls the sequencer.
REQ-004 SHALL have port data_in, input, 8 bits: data bus byte, the opcode source at fetch.
REQ-005 SHALL have port x_next, input, 1 bit: NEXT bit of the current microcode word.
REQ-006 SHALL have port ir, output, 8 bits: instruction register, microcode ROM address high part.
REQ-007 SHALL have port cycle, output, 6 bits: one-hot cycle (C_N=000000, C_0=000001 ... C_5=100000).
REQ-008 SHALL have port sync, output, 1 bit: high while cycle==C_0 (first cycle of an instruction).
REQ-009 SHALL have port seq_err, output, 1 bit: one-cycle pulse on cycle overflow.
REQ-010 SHALL have port inst_count, output, 16 bits: count of instructions fetched.

Function
REQ-011 SHALL define an advance edge as a rising clk edge with rdy=1 and reset=0; all other edges hold ir, cycle and inst_count unchanged and drive seq_err=0.
REQ-012 SHALL, on an advance edge with x_next=1, load ir<=data_in, set cycle<=C_0 and increment inst_count.
REQ-013 SHALL, on an advance edge with x_next=0 and cycle in C_0..C_4, shift cycle left by one, for example C_2 to C_3; ir SHALL hold.
REQ-014 SHALL, on an advance edge with x_next=0 and cycle==C_N, hold C_N (reset wait).
REQ-015 SHALL, on an advance edge with x_next=0 and cycle==C_5 (overflow), set ir<=8'h00 and cycle<=C_N, and pulse seq_err=1 for exactly one cycle.
REQ-016 SHALL give x_next priority over overflow when both apply at C_5, which is a normal fetch with no seq_err.
REQ-017 SHALL wrap inst_count modulo 2^16 (FFFF to 0000) with no flag.
REQ-018 SHALL derive sync combinationally from the cycle register only, so it stays stable during rdy stalls.
REQ-019 SHALL never let cycle hold any value other than the seven legal encodings.
REQ-020 SHALL have a fetch latency of exactly one advance edge: an opcode on data_in is visible on ir in the next clk cycle.

Reset
REQ-021 SHALL, while reset=1 at a clk edge, set ir=8'h00, cycle=C_N, seq_err=0 and inst_count=0, regardless of rdy or x_next.
REQ-022 SHALL, on reset asserted mid-instruction (any C_k), abandon the instruction; the next edge after release follows REQ-012/014.
REQ-023 SHALL hold no state outside the registers listed in REQ-021 (plus irq_ack when configured).

Configuration
REQ-024 SHALL, with macro K6502_SEQ_IRQ_EN defined, add inputs irq (1 bit, level, active-high) and iflag (1 bit), and output irq_ack (1 bit, registered).
REQ-025 SHALL, with K6502_SEQ_IRQ_EN defined, on an advance edge with x_next=1, irq=1 and iflag=0, load ir<=8'h00 (BRK) instead of data_in and pulse irq_ack=1 for one cycle; inst_count SHALL still increment.
REQ-026 SHALL, with K6502_SEQ_IRQ_EN defined, clear irq_ack to 0 on reset.
REQ-027 SHALL, without K6502_SEQ_IRQ_EN, omit the irq, iflag and irq_ack ports, take ir always from data_in, and otherwise behave identically.

Structure
REQ-028 SHALL take the C_N..C_5 encodings, X_BITS and the NEXT-bit index from shared include k6502_defs.v; the new constants SEQ_CNT_W=16 and OPC_BRK=8'h00 SHALL be added there.
REQ-029 SHALL contain no sub-module; the parent core instantiates the microcode ROM beside this block, with {ir,cycle} feeding the ROM and the ROM NEXT bit feeding x_next.

Verification
REQ-030 SHALL check reset: hold reset 3 cycles, rdy=1, x_next=1, data_in=A9, then release -> ir=00, cycle=000000 during reset; after the first edge, ir=A9, cycle=000001, sync=1, inst_count=1.
REQ-031 SHALL check JMP ind: ir=6C, x_next=0 for 4 edges and then 1, data_in=EA -> cycle walks 000001, 000010, 000100, 001000, 010000, then ir=EA, cycle=000001.
REQ-032 SHALL check a stall: at cycle=000100 drive rdy=0 for 5 cycles -> ir, cycle, inst_count and sync unchanged; the sequence resumes on the first rdy=1 edge.
REQ-033 SHALL check overflow: at C_5 with x_next=0 -> ir=00, cycle=000000, seq_err=1 for one cycle; with x_next=1 at C_5 -> normal fetch, seq_err=0.
REQ-034 SHALL check the counter: preload via 65535 fetches, then one more -> inst_count=0000.
REQ-035 SHALL check IRQ (K6502_SEQ_IRQ_EN): irq=1, iflag=0 at fetch with data_in=A2 -> ir=00, irq_ack pulses once; with iflag=1 -> ir=A2, irq_ack=0.

Source files
------------

// File: rtl/k6502_seq_pkg.sv
// Types and constants for the k6502 instruction sequencer, built on k6502_defs.v.
package k6502_seq_pkg;

`include "k6502_defs.v"

  localparam int CNT_W = `SEQ_CNT_W;
  localparam logic [7:0] IR_BRK = `OPC_BRK;

  typedef enum logic [5:0] {
    C_N = `C_N,
    C_0 = `C_0,
    C_1 = `C_1,
    C_2 = `C_2,
    C_3 = `C_3,
    C_4 = `C_4,
    C_5 = `C_5
  } cycle_t;

  typedef struct packed {
    logic [7:0]       ir;
    cycle_t           cycle;
    logic [CNT_W-1:0] inst_count;
  } seq_state_t;

  // C_5 has no successor: falling off the end lands in C_N.
  function automatic cycle_t cycle_succ(input cycle_t c);
    cycle_t r;
    case (c)
      C_0:     r = C_1;
      C_1:     r = C_2;
      C_2:     r = C_3;
      C_3:     r = C_4;
      C_4:     r = C_5;
      default: r = C_N;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/k6502_seq_if.sv
// Sequencer bus: stall/opcode/NEXT in from the core and microcode ROM, {ir,cycle} and status out.
interface k6502_seq_if;
  import k6502_seq_pkg::*;

  logic             rdy;
  logic [7:0]       data_in;
  logic             x_next;
  logic [7:0]       ir;
  cycle_t           cycle;
  logic             sync;
  logic             seq_err;
  logic [CNT_W-1:0] inst_count;
`ifdef K6502_SEQ_IRQ_EN
  logic             irq;
  logic             iflag;
  logic             irq_ack;

  modport master (
    output rdy, data_in, x_next, irq, iflag,
    input  ir, cycle, sync, seq_err, inst_count, irq_ack
  );
  modport slave (
    input  rdy, data_in, x_next, irq, iflag,
    output ir, cycle, sync, seq_err, inst_count, irq_ack
  );
`else
  modport master (
    output rdy, data_in, x_next,
    input  ir, cycle, sync, seq_err, inst_count
  );
  modport slave (
    input  rdy, data_in, x_next,
    output ir, cycle, sync, seq_err, inst_count
  );
`endif
endinterface

// File: rtl/k6502_defs.v
// Shared k6502 core constants: cycle encodings, microcode word layout and opcode values.
`ifndef K6502_DEFS_V
`define K6502_DEFS_V

// One-hot cycle encodings; C_N is the idle/reset-wait state.
`define C_N 6'b000000
`define C_0 6'b000001
`define C_1 6'b000010
`define C_2 6'b000100
`define C_3 6'b001000
`define C_4 6'b010000
`define C_5 6'b100000

`define X_BITS 32
`define X_NEXT 0

`define SEQ_CNT_W 16
`define OPC_BRK 8'h00

`endif

// File: rtl/k6502_seq.sv
// k6502 instruction sequencer: opcode fetch into ir, one-hot cycle walk, 1 advance edge fetch latency.
// rdy=0 freezes all state; K6502_SEQ_IRQ_EN adds irq/iflag/irq_ack (BRK injection at fetch).
module k6502_seq
  import k6502_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  k6502_seq_if.slave bus
);

  seq_state_t cur;
  seq_state_t nxt;
  logic       seq_err_q;
  logic       seq_err_d;
  logic       fetch_brk;

`ifdef K6502_SEQ_IRQ_EN
  logic irq_ack_q;

  assign fetch_brk = bus.irq & ~bus.iflag;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_ack_q <= 1'b0;
    end else begin
      irq_ack_q <= bus.rdy & bus.x_next & fetch_brk;
    end
  end

  assign bus.irq_ack = irq_ack_q;
`else
  assign fetch_brk = 1'b0;
`endif

  // NEXT wins over overflow, so a fetch at C_5 is a normal fetch.
  always_comb begin
    nxt       = cur;
    seq_err_d = 1'b0;
    if (bus.rdy) begin
      if (bus.x_next) begin
        nxt.ir         = fetch_brk ? IR_BRK : bus.data_in;
        nxt.cycle      = C_0;
        nxt.inst_count = cur.inst_count + CNT_W'(1);
      end else if (cur.cycle == C_5) begin
        nxt.ir    = IR_BRK;
        nxt.cycle = C_N;
        seq_err_d = 1'b1;
      end else begin
        nxt.cycle = cycle_succ(cur.cycle);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= '{ir: IR_BRK, cycle: C_N, inst_count: '0};
      seq_err_q <= 1'b0;
    end else begin
      cur       <= nxt;
      seq_err_q <= seq_err_d;
    end
  end

  assign bus.ir         = cur.ir;
  assign bus.cycle      = cur.cycle;
  assign bus.sync       = (cur.cycle == C_0);
  assign bus.seq_err    = seq_err_q;
  assign bus.inst_count = cur.inst_count;

  a_cycle_legal: assert property (@(posedge clk) disable iff (reset)
    cur.cycle inside {C_N, C_0, C_1, C_2, C_3, C_4, C_5});

  a_err_lands_idle: assert property (@(posedge clk) disable iff (reset)
    seq_err_q |-> (cur.cycle == C_N) && (cur.ir == IR_BRK));

endmodule

// File: tb/tb_k6502_seq.sv
// Scoreboard bench for k6502_seq: directed vectors push expected state, a negedge monitor pops and compares.
module tb_k6502_seq;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  k6502_seq_if bus();
  k6502_seq dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    string       nm;
    logic [7:0]  ir;
    logic [5:0]  cyc;
    logic        err;
    logic [15:0] cnt;
    logic        ack;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n      = 0;

`ifdef K6502_SEQ_IRQ_EN
  logic irq_req   = 1'b0;
  logic iflag_req = 1'b0;
`endif

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h want %h", nm, fld, act, req);
    end
  endtask

  // Monitor: every negedge with an outstanding expectation compares the post-edge state.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.nm, "ir",      16'(bus.ir),         16'(e.ir));
      chk(e.nm, "cycle",   16'(bus.cycle),      16'(e.cyc));
      chk(e.nm, "sync",    16'(bus.sync),       16'(e.cyc == 6'b000001));
      chk(e.nm, "seq_err", 16'(bus.seq_err),    16'(e.err));
      chk(e.nm, "count",   bus.inst_count,      e.cnt);
`ifdef K6502_SEQ_IRQ_EN
      chk(e.nm, "irq_ack", 16'(bus.irq_ack),    16'(e.ack));
`endif
    end
  end

  task automatic drive(input logic rs, input logic r, input logic x, input logic [7:0] d);
    @(negedge clk);
    #2;
    reset       = rs;
    bus.rdy     = r;
    bus.x_next  = x;
    bus.data_in = d;
`ifdef K6502_SEQ_IRQ_EN
    bus.irq     = irq_req;
    bus.iflag   = iflag_req;
`endif
  endtask

  task automatic step(input string nm, input logic rs, input logic r, input logic x, input logic [7:0] d,
                      input logic [7:0] eir, input logic [5:0] ecyc, input logic eerr,
                      input logic [15:0] ecnt, input logic eack = 1'b0);
    exp_t e;
    drive(rs, r, x, d);
    e.nm  = nm;
    e.ir  = eir;
    e.cyc = ecyc;
    e.err = eerr;
    e.cnt = ecnt;
    e.ack = eack;
    sb.push_back(e);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, want summary first");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rdy     = 1'b1;
    bus.x_next  = 1'b1;
    bus.data_in = 8'hA9;
`ifdef K6502_SEQ_IRQ_EN
    bus.irq     = 1'b0;
    bus.iflag   = 1'b0;
`endif

    // Reset held 3 edges with fetch requested, then release.
    repeat (3) step("rst", 1, 1, 1, 8'hA9, 8'h00, 6'b000000, 0, 16'd0);
    n = 1;
    step("rst_rel", 0, 1, 1, 8'hA9, 8'hA9, 6'b000001, 0, 16'(n));

    // JMP (ind): four NEXT=0 edges then fetch.
    n++;
    step("jmp_fetch", 0, 1, 1, 8'h6C, 8'h6C, 6'b000001, 0, 16'(n));
    step("jmp_c1",    0, 1, 0, 8'hFF, 8'h6C, 6'b000010, 0, 16'(n));
    step("jmp_c2",    0, 1, 0, 8'hFF, 8'h6C, 6'b000100, 0, 16'(n));
    step("jmp_c3",    0, 1, 0, 8'hFF, 8'h6C, 6'b001000, 0, 16'(n));
    step("jmp_c4",    0, 1, 0, 8'hFF, 8'h6C, 6'b010000, 0, 16'(n));
    n++;
    step("jmp_next",  0, 1, 1, 8'hEA, 8'hEA, 6'b000001, 0, 16'(n));

    // Stall at C_2 with a fetch presented: nothing may move.
    step("stl_c1", 0, 1, 0, 8'h00, 8'hEA, 6'b000010, 0, 16'(n));
    step("stl_c2", 0, 1, 0, 8'h00, 8'hEA, 6'b000100, 0, 16'(n));
    repeat (5) step("stall", 0, 0, 1, 8'h55, 8'hEA, 6'b000100, 0, 16'(n));
    step("stl_resume", 0, 1, 0, 8'h00, 8'hEA, 6'b001000, 0, 16'(n));

    // Overflow past C_5, then reset-wait hold in C_N.
    step("ovf_c4",   0, 1, 0, 8'h33, 8'hEA, 6'b010000, 0, 16'(n));
    step("ovf_c5",   0, 1, 0, 8'h33, 8'hEA, 6'b100000, 0, 16'(n));
    step("ovf",      0, 1, 0, 8'h33, 8'h00, 6'b000000, 1, 16'(n));
    step("ovf_wait", 0, 1, 0, 8'h33, 8'h00, 6'b000000, 0, 16'(n));
    n++;
    step("ovf_fetch", 0, 1, 1, 8'hA5, 8'hA5, 6'b000001, 0, 16'(n));

    // NEXT at C_5 is an ordinary fetch.
    for (int k = 1; k <= 5; k++) step("pri_walk", 0, 1, 0, 8'h00, 8'hA5, 6'b000001 << k, 0, 16'(n));
    n++;
    step("pri_fetch", 0, 1, 1, 8'h4C, 8'h4C, 6'b000001, 0, 16'(n));

    // sync must stay high through a stall at C_0.
    step("c0_stall", 0, 0, 0, 8'h99, 8'h4C, 6'b000001, 0, 16'(n));

    // Reset mid-instruction abandons it; next edge waits in C_N.
    step("mid_c1",    0, 1, 0, 8'h00, 8'h4C, 6'b000010, 0, 16'(n));
    step("mid_rst",   1, 1, 1, 8'h77, 8'h00, 6'b000000, 0, 16'd0);
    step("mid_wait",  0, 1, 0, 8'h77, 8'h00, 6'b000000, 0, 16'd0);
    n = 1;
    step("mid_fetch", 0, 1, 1, 8'h11, 8'h11, 6'b000001, 0, 16'(n));

`ifdef K6502_SEQ_IRQ_EN
    irq_req = 1'b1; iflag_req = 1'b0;
    n++;
    step("irq_fetch", 0, 1, 1, 8'hA2, 8'h00, 6'b000001, 0, 16'(n), 1'b1);
    step("irq_c1",    0, 1, 0, 8'hA2, 8'h00, 6'b000010, 0, 16'(n), 1'b0);
    iflag_req = 1'b1;
    n++;
    step("irq_mask",  0, 1, 1, 8'hA2, 8'hA2, 6'b000001, 0, 16'(n), 1'b0);
    irq_req = 1'b0; iflag_req = 1'b0;
`endif

    // Counter wrap: FFFE unchecked fetches, then FFFF, then 0000.
    step("cnt_rst", 1, 1, 1, 8'h00, 8'h00, 6'b000000, 0, 16'd0);
    repeat (65534) drive(0, 1, 1, 8'h5A);
    step("cnt_ffff", 0, 1, 1, 8'hC3, 8'hC3, 6'b000001, 0, 16'hFFFF);
    step("cnt_wrap", 0, 1, 1, 8'h22, 8'h22, 6'b000001, 0, 16'h0000);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard", "left", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
